// File: rtl/rocketcpu_dbg_pkg.sv
// Shared constants and types for the host debug bridge: opcodes, status bytes, FSM states.
package rocketcpu_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] ST_OK    = 8'hA5;
  localparam logic [7:0] ST_ERR   = 8'hEE;

  localparam int unsigned RESP_BYTES = 5;
  localparam int unsigned RESP_W     = 8 * RESP_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_e;

endpackage

// File: rtl/rocketcpu_dbg_timeout.sv
// Clearable saturating cycle counter; tc_o flags that the current cycle is the last one allowed.
module rocketcpu_dbg_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // tc_q tracks cnt_q >= TIMEOUT-1, so the abort lands after exactly TIMEOUT cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d >= CNT_LAST);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/rocketcpu_dbg_bridge.sv
// Host byte-stream to single-beat Wishbone initiator: decodes a command frame,
// runs one bus cycle, and streams back a status/readback response.
module rocketcpu_dbg_bridge
  import rocketcpu_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  state_e            state_q;
  logic [1:0]        idx_q;
  logic              we_q;
  logic [31:0]       adr_q;
  logic [31:0]       dat_q;
  logic              cyc_q;
  logic [RESP_W-1:0] resp_q;
  logic [2:0]        rem_q;
  logic              tx_valid_q;
  logic              rx_ready_q;
  logic              busy_q;
  logic              tmo;

  logic rx_fire;
  assign rx_fire = i_rx_valid && rx_ready_q;

  rocketcpu_dbg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i  (i_wb_clk),
    .rst_ni (i_rst_n),
    .clr_i  (state_q != S_BUS),
    .en_i   ((state_q == S_BUS) && !i_wb_ack),
    .tc_o   (tmo)
  );

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      we_q       <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      cyc_q      <= 1'b0;
      resp_q     <= '0;
      rem_q      <= 3'd0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            busy_q <= 1'b1;
            idx_q  <= 2'd0;
            if ((i_rx_data == OP_WRITE) || (i_rx_data == OP_READ)) begin
              we_q    <= (i_rx_data == OP_WRITE);
              state_q <= S_ADDR;
            end else begin
              resp_q     <= {32'd0, ST_ERR};
              rem_q      <= 3'd1;
              tx_valid_q <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_RESP;
            end
          end
        end

        // Fields arrive LSB first, so shift each byte in from the top
        S_ADDR: begin
          if (rx_fire) begin
            adr_q <= {i_rx_data, adr_q[31:8]};
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (we_q) begin
                state_q <= S_WDATA;
              end else begin
                cyc_q      <= 1'b1;
                rx_ready_q <= 1'b0;
                state_q    <= S_BUS;
              end
            end
          end
        end

        S_WDATA: begin
          if (rx_fire) begin
            dat_q <= {i_rx_data, dat_q[31:8]};
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              cyc_q      <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_BUS;
            end
          end
        end

        // Ack is checked before the timeout so a last-cycle ack still succeeds
        S_BUS: begin
          if (i_wb_ack) begin
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
            if (we_q) begin
              resp_q <= {32'd0, ST_OK};
              rem_q  <= 3'd1;
            end else begin
              resp_q <= {i_wb_rdt, ST_OK};
              rem_q  <= 3'd5;
            end
          end else if (tmo) begin
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            resp_q     <= {32'd0, ST_ERR};
            rem_q      <= 3'd1;
            state_q    <= S_RESP;
          end
        end

        S_RESP: begin
          if (i_tx_ready) begin
            if (rem_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              resp_q <= {8'd0, resp_q[RESP_W-1:8]};
              rem_q  <= rem_q - 3'd1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready = rx_ready_q;
  assign o_tx_data  = resp_q[7:0];
  assign o_tx_valid = tx_valid_q;
  assign o_wb_adr   = {adr_q[31:2], 2'b00};
  assign o_wb_dat   = dat_q;
  assign o_wb_sel   = 4'hF;
  assign o_wb_we    = we_q;
  assign o_wb_cyc   = cyc_q;
  assign o_busy     = busy_q;

endmodule
